// File: rtl/iic_cfg_seq_if.sv
// Bus between the config sequencer and the IIC_M byte engine.
// master = sequencer side, slave = IIC_M side.
interface iic_cfg_seq_if;
  logic        iic_req;
  logic        iic_mode;
  logic [6:0]  iic_addr_divice;
  logic [15:0] iic_addr_reg;
  logic [7:0]  iic_wr_data;
  logic        iic_wr_valid;
  logic [7:0]  iic_wr_length;
  logic [7:0]  iic_rd_data;
  logic        iic_rd_valid;
  logic [7:0]  iic_rd_length;
  logic        iic_busy;
  logic        iic_done;

  modport master (
    output iic_req, iic_mode, iic_addr_divice, iic_addr_reg, iic_wr_data,
           iic_wr_length, iic_rd_length,
    input  iic_wr_valid, iic_rd_data, iic_rd_valid, iic_busy, iic_done
  );

  modport slave (
    input  iic_req, iic_mode, iic_addr_divice, iic_addr_reg, iic_wr_data,
           iic_wr_length, iic_rd_length,
    output iic_wr_valid, iic_rd_data, iic_rd_valid, iic_busy, iic_done
  );
endinterface

// File: rtl/iic_cfg_seq.sv
// Register-init sequencer: walks a sync-ROM table of {op,dev,reg,data} entries and
// drives one single-byte IIC_M transaction per entry, with verify, retry and timeout.
module iic_cfg_seq #(
  parameter  int TABLE_DEPTH    = 64,
  parameter  int SYSCLK_FREQ    = 50_000_000,
  parameter  int TIMEOUT_CYCLES = 2_000_000,
  parameter  int MAX_RETRY      = 3,
  localparam int AW             = $clog2(TABLE_DEPTH)
) (
  input  logic          sysclk,
  input  logic          rstn,
  input  logic          cfg_start,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [AW-1:0] cfg_err_idx,
  output logic [AW-1:0] tbl_addr,
  input  logic [33:0]   tbl_data,
  iic_cfg_seq_if.master iic
);

  localparam int MS_CYC = (SYSCLK_FREQ / 1000 > 0) ? SYSCLK_FREQ / 1000 : 1;
  localparam int MW     = $clog2(MS_CYC + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW     = $clog2(MAX_RETRY + 1) > 0 ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [MW-1:0] MS_LAST  = MW'(MS_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(TABLE_DEPTH - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_WV  = 2'b01;
  localparam logic [1:0] OP_DLY = 2'b10;

  // Bit order matches the ROM word so a table word casts straight in.
  typedef struct packed {
    logic        mask_en;
    logic [1:0]  op;
    logic [6:0]  dev;
    logic [15:0] rega;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD,
    CHECK, DELAY, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] tbl_addr_q, tbl_addr_d;
  entry_t        ent_q, ent_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [MW-1:0] ms_q, ms_d;
  logic [7:0]    dly_q, dly_d;
  logic [7:0]    rd_q, rd_d;
  logic          rd_seen_q, rd_seen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_idx_q, err_idx_d;
  logic          req_q, req_d;
  logic          mode_q, mode_d;
  logic          fail;
  logic [7:0]    mask;

  // Bit 0 is a reserved bit on masked entries and never compared.
  assign mask = ent_q.mask_en ? 8'hFE : 8'hFF;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tbl_addr_d = tbl_addr_q;
    ent_d      = ent_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    ms_d       = ms_q;
    dly_d      = dly_q;
    rd_d       = rd_q;
    rd_seen_d  = rd_seen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    req_d      = 1'b0;
    mode_d     = mode_q;
    fail       = 1'b0;

    case (state_q)
      IDLE: if (cfg_start) begin
        busy_d     = 1'b1;
        err_d      = 1'b0;
        idx_d      = '0;
        tbl_addr_d = '0;
        retry_d    = '0;
        state_d    = FETCH;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ent_d = entry_t'(tbl_data);
        case (tbl_data[32:31])
          OP_WR, OP_WV: state_d = ISSUE_WR;
          OP_DLY: begin
            dly_d   = tbl_data[7:0];
            ms_d    = '0;
            state_d = (tbl_data[7:0] == 8'd0) ? NEXT : DELAY;
          end
          default: state_d = DONE;
        endcase
      end
      ISSUE_WR: if (!iic.iic_busy) begin
        req_d   = 1'b1;
        mode_d  = 1'b0;
        tmo_d   = '0;
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (iic.iic_done)          state_d = (ent_q.op == OP_WV) ? ISSUE_RD : NEXT;
        else if (tmo_q == TMO_LAST) fail   = 1'b1;
        else                        tmo_d  = tmo_q + 1'b1;
      end
      ISSUE_RD: if (!iic.iic_busy) begin
        req_d     = 1'b1;
        mode_d    = 1'b1;
        tmo_d     = '0;
        rd_seen_d = 1'b0;
        state_d   = WAIT_RD;
      end
      WAIT_RD: begin
        if (iic.iic_rd_valid) begin
          rd_d      = iic.iic_rd_data;
          rd_seen_d = 1'b1;
        end
        // A done with no data strobe at all counts as a failed read.
        if (iic.iic_done) begin
          if (rd_seen_q || iic.iic_rd_valid) state_d = CHECK;
          else                               fail    = 1'b1;
        end else if (tmo_q == TMO_LAST) fail  = 1'b1;
        else                            tmo_d = tmo_q + 1'b1;
      end
      CHECK: begin
        if (((rd_q ^ ent_q.data) & mask) != 8'd0) fail    = 1'b1;
        else                                      state_d = NEXT;
      end
      DELAY: begin
        if (ms_q == MS_LAST) begin
          ms_d  = '0;
          dly_d = dly_q - 8'd1;
          if (dly_q == 8'd1) state_d = NEXT;
        end else begin
          ms_d = ms_q + 1'b1;
        end
      end
      NEXT: begin
        retry_d = '0;
        // The last slot ends the run even without an END entry.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          tbl_addr_d = idx_q + 1'b1;
          state_d    = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      if (retry_q < RTY_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = ISSUE_WR;
      end else begin
        err_d     = 1'b1;
        err_idx_d = idx_q;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tbl_addr_q <= '0;
      ent_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      ms_q       <= '0;
      dly_q      <= '0;
      rd_q       <= '0;
      rd_seen_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      req_q      <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tbl_addr_q <= tbl_addr_d;
      ent_q      <= ent_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      ms_q       <= ms_d;
      dly_q      <= dly_d;
      rd_q       <= rd_d;
      rd_seen_q  <= rd_seen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      req_q      <= req_d;
      mode_q     <= mode_d;
    end
  end

  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign cfg_err_idx = err_idx_q;
  assign tbl_addr    = tbl_addr_q;

  assign iic.iic_req         = req_q;
  assign iic.iic_mode        = mode_q;
  assign iic.iic_addr_divice = ent_q.dev;
  assign iic.iic_addr_reg    = ent_q.rega;
  assign iic.iic_wr_data     = ent_q.data;
  assign iic.iic_wr_length   = 8'd1;
  assign iic.iic_rd_length   = 8'd1;

endmodule
